rtc_hms_counter: RTL and testbench
==================================

Name: rtc_hms_counter

Overview:
- Consumes the 1 Hz square wave produced by the clock divider stage and keeps wall-clock time as six BCD digits, HH:MM:SS, in 24-hour format.
- The digits feed the VGA character renderer.
- A small three-state FSM lets the user set hours and minutes with two debounced push-button pulses.
- All logic runs in the single system clock domain; the 1 Hz input is treated as an asynchronous level and edge-detected.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on clk_1hz (must be ≥2).
- INIT_HOUR, 0, hour value loaded on reset (0–23, binary).
- INIT_MIN, 0, minute value loaded on reset (0–59, binary).

Ports:
- clk_in  input  1  system clock (100 MHz on board).
- rst  input  1  synchronous, active-high reset.
- clk_1hz  input  1  divided 1 Hz clock from the divider stage, sampled as data.
- btn_mode  input  1  single-cycle pulse, debounced upstream; advances the FSM.
- btn_inc  input  1  single-cycle pulse, debounced upstream; increments the selected field.
- hour_tens  output  2  BCD tens digit of hours (0–2).
- hour_ones  output  4  BCD ones digit of hours.
- min_tens  output  3  BCD tens digit of minutes (0–5).
- min_ones  output  4  BCD ones digit of minutes.
- sec_tens  output  3  BCD tens digit of seconds (0–5).
- sec_ones  output  4  BCD ones digit of seconds.
- mode  output  2  current FSM state: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.
- sec_tick  output  1  one-cycle pulse on each detected clk_1hz rising edge.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clk_in.
- Reset state:
  - digits = INIT_HOUR:INIT_MIN:00 converted to BCD;
  - mode = RUN;
  - sec_tick = 0;
  - all synchronizer and edge-history flops = 1, so a clk_1hz that is high at reset produces no spurious tick.
- Edge detection:
  - clk_1hz passes through SYNC_STAGES flops, then one history flop.
  - sec_tick = last_sync & ~history, registered.
  - Latency: sec_tick rises SYNC_STAGES+1 cycles after clk_1hz rises and lasts exactly one cycle.
- Digit update: digits update in the cycle after sec_tick is high. All digit outputs are registered.
- RUN state, on sec_tick: increment seconds with full BCD carry ripple in one cycle.
  - ones 9 → 0 carries into tens;
  - sec 59 → 00 carries into minutes;
  - min 59 → 00 carries into hours;
  - 23:59:59 → 00:00:00.
  - Hours wrap on 23 → 00, never 24.
- FSM transitions on btn_mode: RUN → SET_HOUR → SET_MIN → RUN.
  - Leaving SET_MIN for RUN clears seconds to 00.
- SET_HOUR: counting is frozen and sec_tick is ignored. btn_inc increments hours, 23 → 00, with no effect on minutes.
- SET_MIN: counting is frozen. btn_inc increments minutes, 59 → 00, with no carry into hours.
- btn_inc in RUN: ignored.
- Simultaneous btn_mode and btn_inc: btn_mode wins and btn_inc is dropped that cycle.
- Simultaneous sec_tick and btn_mode in RUN: the tick is applied and the state advances in the same cycle.
- Reset mid-count or mid-set: returns to reset state on the next edge regardless of state.
- Illegal mode encoding 3: the next state is RUN.
- Digits never hold a non-BCD value or an out-of-range time.

Decomposition:
- Shared package rtc_pkg contains:
  - mode encodings MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN;
  - BCD limits SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
- One sub-module, rise_sync_detect: parameterised SYNC_STAGES synchronizer plus rising-edge pulse, with reset-to-1 flops. Reusable for the button inputs later.
- BCD counting stays inline in rtc_hms_counter.

Test Plan:
- Reset behaviour: rst high for 3 cycles with clk_1hz held high, then release → digits 00:00:00, mode = 0, no sec_tick until clk_1hz goes low then high.
- Tick latency: clk_1hz rises once → sec_tick high exactly at cycle 3 after the rise for one cycle, and sec_ones = 1 on the following cycle.
- Full rollover: reset to INIT 23:59, drive 59 rising edges then one more → 23:59:59 → 00:00:00. Also check 00:09:59 → 00:10:00.
- Set mode: btn_mode, btn_inc ×25 → hours = 01 (wrapped past 23). Then btn_mode, btn_inc ×61 → minutes = 01 with hours still 01. Ticks during both set states leave all digits unchanged.
- Return to RUN: from SET_MIN with seconds at 37, pulse btn_mode → mode = 0, seconds = 00, and counting resumes on the next edge.
- Collisions: btn_mode and btn_inc in the same cycle while in SET_HOUR → mode = 2, hours unchanged. A reset pulse asserted during SET_MIN → mode = 0 and digits back to INIT.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared encodings and limits for the HH:MM:SS real-time clock.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rtc_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Split a small binary value into its decimal tens / ones digits.
  function automatic int bcd_tens(input int v);
    return v / 10;
  endfunction

  function automatic int bcd_ones(input int v);
    return v % 10;
  endfunction

endpackage

// File: rtl/rise_sync_detect.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse on its rising edge.
// Latency: pulse is high SYNC_STAGES+1 cycles after din rises; SYNC_STAGES must be >= 2.
// Backpressure: none; free-running, every detected edge produces exactly one pulse.
module rise_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   pulse_q, pulse_d;

  // Shift the level through the synchronizer and compare against one cycle of history.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    hist_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Flops reset high so a level that is already high at reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/rtc_hms_counter.sv
// 24-hour BCD HH:MM:SS time keeper driven by an edge-detected 1 Hz level, with hour/minute set mode.
// Latency: digits update the cycle after sec_tick (sec_tick is SYNC_STAGES+1 cycles after clk_1hz rises).
// Backpressure: none; button pulses and ticks are consumed on the cycle they arrive.
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int INIT_HOUR   = 0,
  parameter int INIT_MIN    = 0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam logic [1:0] HOUR_T_MAX = 2'(bcd_tens(HOUR_MAX));
  localparam logic [3:0] HOUR_O_MAX = 4'(bcd_ones(HOUR_MAX));
  localparam logic [2:0] MIN_T_MAX  = 3'(bcd_tens(MIN_MAX));
  localparam logic [2:0] SEC_T_MAX  = 3'(bcd_tens(SEC_MAX));

  localparam logic [1:0] INIT_HT = 2'(bcd_tens(INIT_HOUR));
  localparam logic [3:0] INIT_HO = 4'(bcd_ones(INIT_HOUR));
  localparam logic [2:0] INIT_MT = 3'(bcd_tens(INIT_MIN));
  localparam logic [3:0] INIT_MO = 4'(bcd_ones(INIT_MIN));

  mode_e      mode_q, mode_d;
  logic [1:0] hour_tens_q, hour_tens_d;
  logic [3:0] hour_ones_q, hour_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  logic       tick;

  // Incremented-field candidates, shared by run-mode counting and set-mode editing.
  logic [1:0] hour_inc_t;
  logic [3:0] hour_inc_o;
  logic [2:0] min_inc_t;
  logic [3:0] min_inc_o;
  logic       min_wrap;
  logic [2:0] sec_inc_t;
  logic [3:0] sec_inc_o;
  logic       sec_wrap;

  rise_sync_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sec_edge (
    .clk   (clk_in),
    .rst   (rst),
    .din   (clk_1hz),
    .pulse (tick)
  );

  // Next value of each field on increment; >= compares keep any stray code inside the legal range.
  always_comb begin
    hour_inc_t = hour_tens_q;
    hour_inc_o = hour_ones_q + 4'd1;
    if ((hour_tens_q == HOUR_T_MAX && hour_ones_q >= HOUR_O_MAX) || hour_tens_q > HOUR_T_MAX) begin
      hour_inc_t = 2'd0;
      hour_inc_o = 4'd0;
    end else if (hour_ones_q >= 4'd9) begin
      hour_inc_t = hour_tens_q + 2'd1;
      hour_inc_o = 4'd0;
    end

    min_inc_t = min_tens_q;
    min_inc_o = min_ones_q + 4'd1;
    min_wrap  = 1'b0;
    if (min_ones_q >= 4'd9) begin
      min_inc_o = 4'd0;
      if (min_tens_q >= MIN_T_MAX) begin
        min_inc_t = 3'd0;
        min_wrap  = 1'b1;
      end else begin
        min_inc_t = min_tens_q + 3'd1;
      end
    end

    sec_inc_t = sec_tens_q;
    sec_inc_o = sec_ones_q + 4'd1;
    sec_wrap  = 1'b0;
    if (sec_ones_q >= 4'd9) begin
      sec_inc_o = 4'd0;
      if (sec_tens_q >= SEC_T_MAX) begin
        sec_inc_t = 3'd0;
        sec_wrap  = 1'b1;
      end else begin
        sec_inc_t = sec_tens_q + 3'd1;
      end
    end
  end

  // Mode FSM and digit update: ticks count only in RUN, btn_mode always beats btn_inc.
  always_comb begin
    mode_d      = mode_q;
    hour_tens_d = hour_tens_q;
    hour_ones_d = hour_ones_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;

    case (mode_q)
      MODE_RUN: begin
        if (tick) begin
          sec_tens_d = sec_inc_t;
          sec_ones_d = sec_inc_o;
          if (sec_wrap) begin
            min_tens_d = min_inc_t;
            min_ones_d = min_inc_o;
            if (min_wrap) begin
              hour_tens_d = hour_inc_t;
              hour_ones_d = hour_inc_o;
            end
          end
        end
        if (btn_mode) begin
          mode_d = MODE_SET_HOUR;
        end
      end
      MODE_SET_HOUR: begin
        if (btn_mode) begin
          mode_d = MODE_SET_MIN;
        end else if (btn_inc) begin
          hour_tens_d = hour_inc_t;
          hour_ones_d = hour_inc_o;
        end
      end
      MODE_SET_MIN: begin
        if (btn_mode) begin
          mode_d     = MODE_RUN;
          sec_tens_d = 3'd0;
          sec_ones_d = 4'd0;
        end else if (btn_inc) begin
          min_tens_d = min_inc_t;
          min_ones_d = min_inc_o;
        end
      end
      default: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  // State and digit registers, loaded with the configured start time on reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      mode_q      <= MODE_RUN;
      hour_tens_q <= INIT_HT;
      hour_ones_q <= INIT_HO;
      min_tens_q  <= INIT_MT;
      min_ones_q  <= INIT_MO;
      sec_tens_q  <= 3'd0;
      sec_ones_q  <= 4'd0;
    end else begin
      mode_q      <= mode_d;
      hour_tens_q <= hour_tens_d;
      hour_ones_q <= hour_ones_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
    end
  end

  assign hour_tens = hour_tens_q;
  assign hour_ones = hour_ones_q;
  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign mode      = mode_q;
  assign sec_tick  = tick;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Self-checking bench for rtc_hms_counter: scoreboard of expected time snapshots from a reference model.
module tb_rtc_hms_counter;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] ho;
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic [1:0] md;
  } snap_t;

  logic       clk_in = 1'b0;
  logic       rst, clk_1hz, btn_mode, btn_inc;

  logic [1:0] hour_tens, b_hour_tens;
  logic [3:0] hour_ones, b_hour_ones;
  logic [2:0] min_tens, b_min_tens;
  logic [3:0] min_ones, b_min_ones;
  logic [2:0] sec_tens, b_sec_tens;
  logic [3:0] sec_ones, b_sec_ones;
  logic [1:0] mode, b_mode;
  logic       sec_tick, b_sec_tick;

  int checks = 0;
  int errors = 0;
  snap_t sb[$];

  // Reference model state (binary)
  int m_h, m_m, m_s, m_mode;

  rtc_hms_counter dut (
    .clk_in(clk_in), .rst(rst), .clk_1hz(clk_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .mode(mode), .sec_tick(sec_tick)
  );

  rtc_hms_counter #(.SYNC_STAGES(2), .INIT_HOUR(23), .INIT_MIN(59)) dut_b (
    .clk_in(clk_in), .rst(rst), .clk_1hz(clk_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_tens(b_hour_tens), .hour_ones(b_hour_ones), .min_tens(b_min_tens), .min_ones(b_min_ones),
    .sec_tens(b_sec_tens), .sec_ones(b_sec_ones), .mode(b_mode), .sec_tick(b_sec_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.ht = 2'(m_h / 10);
    s.ho = 4'(m_h % 10);
    s.mt = 3'(m_m / 10);
    s.mo = 4'(m_m % 10);
    s.st = 3'(m_s / 10);
    s.so = 4'(m_s % 10);
    s.md = 2'(m_mode);
    return s;
  endfunction

  function automatic snap_t obs_a();
    return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones, mode};
  endfunction

  function automatic snap_t obs_b();
    return {b_hour_tens, b_hour_ones, b_min_tens, b_min_ones, b_sec_tens, b_sec_ones, b_mode};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d mode=%0d", s.ht, s.ho, s.mt, s.mo, s.st, s.so, s.md);
  endfunction

  function automatic void m_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
  endfunction

  function automatic void m_tick();
    if (m_mode == 0) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0;
        m_m++;
        if (m_m == 60) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
        end
      end
    end
  endfunction

  function automatic void m_btn(bit bm, bit bi);
    if (bm) begin
      if (m_mode == 2) m_s = 0;
      m_mode = (m_mode + 1) % 3;
    end else if (bi) begin
      if (m_mode == 1) m_h = (m_h + 1) % 24;
      else if (m_mode == 2) m_m = (m_m + 1) % 60;
    end
  endfunction

  // One-cycle button pulse; the model follows the same stimulus.
  task automatic press(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    m_btn(bm, bi);
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  // Raise clk_1hz, wait (bounded) for sec_tick, take one more cycle, then drop it again.
  task automatic drive_tick(output int lat, output logic after);
    clk_1hz = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (sec_tick === 1'b1) begin
        lat = i;
        break;
      end
    end
    step();
    after = sec_tick;
    clk_1hz = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    snap_t e;
    int    nt;
    rst = 1'b1; clk_1hz = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    m_reset();
    sb.push_back(model_snap());
    step();
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL reset_digits: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    checks++;
    if (obs_b() !== snap_t'({2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0, 2'd0})) begin
      errors++;
      $display("FAIL reset_init_b: got %s expected 23:59:00 mode=0", fmt(obs_b()));
    end
    nt = 0;
    repeat (6) begin
      if (sec_tick !== 1'b0) nt++;
      step();
    end
    checks++;
    if (nt != 0) begin
      errors++;
      $display("FAIL reset_no_spurious_tick: got %0d ticks expected 0", nt);
    end
    clk_1hz = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_tick_latency();
    snap_t e;
    int    lat;
    logic  after;
    m_tick();
    sb.push_back(model_snap());
    drive_tick(lat, after);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL tick_latency: got %0d cycles expected 3", lat);
    end
    checks++;
    if (after !== 1'b0) begin
      errors++;
      $display("FAIL tick_width: sec_tick got %b one cycle later expected 0", after);
    end
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL tick_first_second: got %s expected %s", fmt(obs_a()), fmt(e));
    end
  endtask

  task automatic test_carry();
    snap_t e;
    int    lat;
    logic  after;
    press(1, 0);
    press(1, 0);
    repeat (9) press(0, 1);
    press(1, 0);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL carry_setup: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    for (int i = 0; i < 60; i++) begin
      m_tick();
      sb.push_back(model_snap());
      drive_tick(lat, after);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL carry_count[%0d]: got %s expected %s", i, fmt(obs_a()), fmt(e));
      end
    end
  endtask

  task automatic test_set_mode();
    snap_t e;
    int    lat;
    logic  after;
    press(1, 0);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL set_hour_enter: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    m_tick();
    sb.push_back(model_snap());
    drive_tick(lat, after);
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL set_hour_frozen: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    repeat (25) press(0, 1);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL set_hour_wrap: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    press(1, 0);
    repeat (61) press(0, 1);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL set_min_wrap: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    m_tick();
    sb.push_back(model_snap());
    drive_tick(lat, after);
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL set_min_frozen: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    press(1, 0);
  endtask

  task automatic test_return_run();
    snap_t e;
    int    lat;
    logic  after;
    repeat (37) begin
      m_tick();
      drive_tick(lat, after);
    end
    press(1, 0);
    press(1, 0);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL ret_setmin_sec37: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    press(1, 0);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL ret_run_sec_clear: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    m_tick();
    sb.push_back(model_snap());
    drive_tick(lat, after);
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL ret_run_resume: got %s expected %s", fmt(obs_a()), fmt(e));
    end
  endtask

  task automatic test_rollover();
    snap_t e;
    int    lat;
    logic  after;
    press(1, 0);
    while (m_h != 23) press(0, 1);
    press(1, 0);
    while (m_m != 59) press(0, 1);
    press(1, 0);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL roll_setup: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    for (int i = 0; i < 60; i++) begin
      m_tick();
      sb.push_back(model_snap());
      drive_tick(lat, after);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL roll_count[%0d]: got %s expected %s", i, fmt(obs_a()), fmt(e));
      end
    end
  endtask

  task automatic test_tick_mode_collision();
    snap_t e;
    clk_1hz = 1'b1;
    repeat (3) step();
    checks++;
    if (sec_tick !== 1'b1) begin
      errors++;
      $display("FAIL coll_tick_seen: sec_tick got %b expected 1", sec_tick);
    end
    btn_mode = 1'b1;
    m_tick();
    m_btn(1, 0);
    sb.push_back(model_snap());
    step();
    btn_mode = 1'b0;
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL coll_tick_mode: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    clk_1hz = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_collisions();
    snap_t e;
    press(1, 1);
    sb.push_back(model_snap());
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL coll_mode_inc: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    repeat (3) press(0, 1);
    rst = 1'b1;
    m_reset();
    sb.push_back(model_snap());
    step();
    e = sb.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL coll_reset_setmin: got %s expected %s", fmt(obs_a()), fmt(e));
    end
    checks++;
    if (obs_b() !== snap_t'({2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0, 2'd0})) begin
      errors++;
      $display("FAIL coll_reset_init_b: got %s expected 23:59:00 mode=0", fmt(obs_b()));
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tick_latency();
    test_carry();
    test_set_mode();
    test_return_run();
    test_rollover();
    test_tick_mode_collision();
    test_collisions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
